// File: rtl/mult8s_booth4_sklansky_rr_sched_if.sv
// Request/result handshake bundle for the shared signed 8x8 multiplier.
// Requester i owns bits [i] of req_valid/req_ready and byte [8i+7:8i] of req_a/req_b.
interface mult8s_booth4_sklansky_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [15:0]          res_product;
    logic [ID_W-1:0]      res_id;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output res_ready,
        input  req_ready,
        input  res_valid,
        input  res_product,
        input  res_id
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  res_ready,
        output req_ready,
        output res_valid,
        output res_product,
        output res_id
    );
endinterface

// File: rtl/mult8s_booth4_sklansky_rr_sched.sv
// Round-robin scheduler sharing one radix-4 Booth / Sklansky signed 8x8 multiplier.
// Two-stage pipe: S1 holds granted operands, S2 holds the tagged product.
module mult8s_booth4_sklansky (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [8:0]  bx;
    logic [15:0] ax;
    logic [2:0]  trip [4];
    logic [15:0] mag  [4];
    logic [15:0] pp   [4];
    logic [3:0]  one;
    logic [3:0]  two;
    logic [3:0]  neg;
    logic [15:0] corr;

    assign bx = {b, 1'b0};
    assign ax = {{8{a[7]}}, a};

    // Negative digits use ~mag here; the +1 lands in corr at the row's LSB.
    always_comb begin
        corr = '0;
        one  = '0;
        two  = '0;
        neg  = '0;
        for (int j = 0; j < 4; j++) begin
            trip[j] = bx[2*j +: 3];
            one[j]  = trip[j][1] ^ trip[j][0];
            two[j]  = (trip[j] == 3'b100) || (trip[j] == 3'b011);
            neg[j]  = trip[j][2] & ~(trip[j][1] & trip[j][0]);
            if (one[j])
                mag[j] = ax;
            else if (two[j])
                mag[j] = ax << 1;
            else
                mag[j] = '0;
            pp[j] = (neg[j] ? ~mag[j] : mag[j]) << (2*j);
            corr[2*j] = neg[j];
        end
    end

    logic [15:0] s1, c1, s2, c2, s3, c3;

    assign s1 = pp[0] ^ pp[1] ^ pp[2];
    assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign s2 = pp[3] ^ corr ^ s1;
    assign c2 = ((pp[3] & corr) | (pp[3] & s1) | (corr & s1)) << 1;
    assign s3 = s2 ^ c2 ^ c1;
    assign c3 = ((s2 & c2) | (s2 & c1) | (c2 & c1)) << 1;

    logic [15:0] gk [5];
    logic [15:0] pk [5];
    int          src;

    // Sklansky prefix: at level l, bits with index bit l set take the
    // group ending just below their 2^l-aligned block.
    always_comb begin
        for (int l = 0; l < 5; l++) begin
            gk[l] = '0;
            pk[l] = '0;
        end
        src   = 0;
        gk[0] = s3 & c3;
        pk[0] = s3 ^ c3;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i >> l) & 1) != 0) begin
                    src = ((i >> l) << l) - 1;
                    gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][src]);
                    pk[l+1][i] = pk[l][i] & pk[l][src];
                end else begin
                    gk[l+1][i] = gk[l][i];
                    pk[l+1][i] = pk[l][i];
                end
            end
        end
        p = pk[0] ^ {gk[4][14:0], 1'b0};
    end
endmodule

module mult8s_booth4_sklansky_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic clk,
    input logic rst,
    mult8s_booth4_sklansky_rr_sched_if.slave bus
);
    logic [7:0]         a1;
    logic [7:0]         b1;
    logic [ID_W-1:0]    id1;
    logic               v1;
    logic [15:0]        p2;
    logic [ID_W-1:0]    id2;
    logic               v2;
    logic [ID_W-1:0]    ptr;

    logic               s2_free;
    logic               s1_adv;
    logic               s1_free;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               found;
    logic               xfer;
    logic [7:0]         a_sel;
    logic [7:0]         b_sel;
    logic [15:0]        prod;
    logic [ID_W-1:0]    ptr_nxt;
    int                 scan;

    assign s2_free = !v2 | bus.res_ready;
    assign s1_adv  = v1 & s2_free;
    assign s1_free = !v1 | s1_adv;

    // Scan from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        scan  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[scan]) begin
                found       = 1'b1;
                grant[scan] = 1'b1;
                gidx        = ID_W'(scan);
            end
        end
    end

    assign bus.req_ready = grant & {NUM_REQ{s1_free & !rst}};
    assign xfer          = |(bus.req_valid & bus.req_ready);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = bus.req_a[i*8 +: 8];
                b_sel = bus.req_b[i*8 +: 8];
            end
        end
    end

    assign ptr_nxt = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

    mult8s_booth4_sklansky u_mul (
        .a (a1),
        .b (b1),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a1  <= '0;
            b1  <= '0;
            id1 <= '0;
            v1  <= 1'b0;
            p2  <= '0;
            id2 <= '0;
            v2  <= 1'b0;
            ptr <= '0;
        end else begin
            if (xfer) begin
                a1  <= a_sel;
                b1  <= b_sel;
                id1 <= gidx;
                v1  <= 1'b1;
                ptr <= ptr_nxt;
            end else if (s1_adv) begin
                v1 <= 1'b0;
            end
            if (s1_adv) begin
                p2  <= prod;
                id2 <= id1;
                v2  <= 1'b1;
            end else if (bus.res_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    assign bus.res_valid   = v2;
    assign bus.res_product = p2;
    assign bus.res_id      = id2;
endmodule

// File: tb/tb_mult8s_booth4_sklansky_rr_sched.sv
// Directed bench for the round-robin shared signed multiplier.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_mult8s_booth4_sklansky_rr_sched;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mult8s_booth4_sklansky_rr_sched_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    mult8s_booth4_sklansky_rr_sched #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
    endtask

    logic [15:0] e;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;

        // reset state, with requests pending
        tick;
        bus.req_valid = 4'hF;
        mid;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_product", 32'(bus.res_product), 32'h0);
        chk("rst_id", 32'(bus.res_id), 32'h0);
        tick;
        rst           = 1'b0;
        bus.req_valid = '0;

        // single request from requester 2
        set_op(2, 8'h7F, 8'h80);
        bus.req_valid = 4'b0100;
        mid;
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        tick;
        bus.req_valid = '0;
        mid;
        chk("single_c1_valid", 32'(bus.res_valid), 32'h0);
        tick;
        mid;
        chk("single_valid", 32'(bus.res_valid), 32'h1);
        chk("single_product", 32'(bus.res_product), 32'hC080);
        chk("single_id", 32'(bus.res_id), 32'h2);
        tick;

        // contention from reset
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'hFF);
        bus.req_valid = 4'hF;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid;
            chk($sformatf("cont_ready_%0d", k), 32'(bus.req_ready),
                (k < 4) ? (32'h1 << k) : 32'h0);
            if (k >= 2) begin
                e = 16'(1 - k);
                chk($sformatf("cont_valid_%0d", k), 32'(bus.res_valid), 32'h1);
                chk($sformatf("cont_product_%0d", k), 32'(bus.res_product), 32'(e));
                chk($sformatf("cont_id_%0d", k), 32'(bus.res_id), 32'(k - 2));
            end
            tick;
            if (k < 4) bus.req_valid[k] = 1'b0;
        end
        mid;
        chk("cont_drained", 32'(bus.res_valid), 32'h0);
        tick;

        // fairness between requesters 0 and 3
        set_op(0, 8'd10, 8'd7);
        set_op(3, 8'hFB, 8'd7);
        bus.req_valid = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) bus.req_valid = '0;
            mid;
            if (k < 8)
                chk($sformatf("fair_ready_%0d", k), 32'(bus.req_ready),
                    (k % 2 == 0) ? 32'h1 : 32'h8);
            if (k >= 2) begin
                chk($sformatf("fair_valid_%0d", k), 32'(bus.res_valid), 32'h1);
                chk($sformatf("fair_id_%0d", k), 32'(bus.res_id),
                    (k % 2 == 0) ? 32'h0 : 32'h3);
                chk($sformatf("fair_product_%0d", k), 32'(bus.res_product),
                    (k % 2 == 0) ? 32'h0046 : 32'hFFDD);
            end
            tick;
        end

        // backpressure on requester 1
        bus.res_ready = 1'b0;
        set_op(1, 8'h80, 8'h80);
        bus.req_valid = 4'b0010;
        mid;
        chk("bp_accept0", 32'(bus.req_ready), 32'h2);
        tick;
        set_op(1, 8'hFF, 8'hFF);
        mid;
        chk("bp_accept1", 32'(bus.req_ready), 32'h2);
        tick;
        set_op(1, 8'h7F, 8'h7F);
        mid;
        chk("bp_stall_ready", 32'(bus.req_ready), 32'h0);
        chk("bp_stall_valid", 32'(bus.res_valid), 32'h1);
        chk("bp_stall_product", 32'(bus.res_product), 32'h4000);
        chk("bp_stall_id", 32'(bus.res_id), 32'h1);
        tick;
        mid;
        chk("bp_hold_ready", 32'(bus.req_ready), 32'h0);
        chk("bp_hold_product", 32'(bus.res_product), 32'h4000);
        tick;
        bus.res_ready = 1'b1;
        mid;
        chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
        chk("bp_res0", 32'(bus.res_product), 32'h4000);
        tick;
        bus.req_valid = '0;
        mid;
        chk("bp_res1_valid", 32'(bus.res_valid), 32'h1);
        chk("bp_res1", 32'(bus.res_product), 32'h0001);
        tick;
        mid;
        chk("bp_res2_valid", 32'(bus.res_valid), 32'h1);
        chk("bp_res2", 32'(bus.res_product), 32'h3F01);
        tick;
        mid;
        chk("bp_drained", 32'(bus.res_valid), 32'h0);
        tick;

        // reset while both stages are full, ptr non-zero
        bus.res_ready = 1'b0;
        set_op(3, 8'd5, 8'd5);
        bus.req_valid = 4'b1000;
        mid;
        chk("mr_grant3", 32'(bus.req_ready), 32'h8);
        tick;
        set_op(1, 8'd6, 8'd6);
        bus.req_valid = 4'b0010;
        mid;
        chk("mr_grant1", 32'(bus.req_ready), 32'h2);
        tick;
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        mid;
        chk("mr_pre_valid", 32'(bus.res_valid), 32'h1);
        chk("mr_pre_product", 32'(bus.res_product), 32'h0019);
        chk("mr_rst_ready", 32'(bus.req_ready), 32'h0);
        tick;
        rst           = 1'b0;
        bus.req_valid = '0;
        mid;
        chk("mr_post_valid", 32'(bus.res_valid), 32'h0);
        chk("mr_post_product", 32'(bus.res_product), 32'h0);
        chk("mr_post_id", 32'(bus.res_id), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick;
            mid;
            chk($sformatf("mr_no_stale_%0d", k), 32'(bus.res_valid), 32'h0);
        end
        tick;
        set_op(1, 8'd3, 8'hFC);
        set_op(2, 8'd9, 8'd9);
        bus.req_valid = 4'b0110;
        mid;
        chk("mr_ptr_zero", 32'(bus.req_ready), 32'h2);
        tick;
        bus.req_valid = '0;
        mid;
        chk("mr_new_c1", 32'(bus.res_valid), 32'h0);
        tick;
        mid;
        chk("mr_new_valid", 32'(bus.res_valid), 32'h1);
        chk("mr_new_product", 32'(bus.res_product), 32'hFFF4);
        chk("mr_new_id", 32'(bus.res_id), 32'h1);
        tick;
        mid;
        chk("mr_end_idle", 32'(bus.res_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult8s_booth4_sklansky_rr_sched.md
# mult8s_booth4_sklansky_rr_sched

Round-robin scheduler that shares one `mult8s_booth4_sklansky` instance (signed 8x8 -> 16, combinational) among `NUM_REQ` requesters. It registers the granted operands, registers the product, and returns it tagged with the requester index. Valid/ready handshakes on both sides allow one multiply per cycle with full backpressure. It replaces the per-requester registered wrapper wherever several clients need occasional signed 8-bit multiplies.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default 2: width of the requester tag; must equal ceil(log2(NUM_REQ)).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents operands.
- `req_a`  in  NUM_REQ*8  signed multiplicand; requester i drives bits [8i+7:8i].
- `req_b`  in  NUM_REQ*8  signed multiplier; requester i drives bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_product`  out  16  signed product a*b, two's complement.
- `res_id`  out  ID_W  index of the requester that issued the product.

## Operation
- Pipeline stages:
  - S1: operand register `a1`, `b1`, `id1`, `v1`.
  - S2: result register `p2`, `id2`, `v2`.
  - The multiplier's inputs come from S1; its output is captured into S2.
- Flow control:
  - `s2_free = !v2 | res_ready`
  - `s1_adv = v1 & s2_free`
  - `s1_free = !v1 | s1_adv`
- Arbitration:
  - A round-robin pointer `ptr` names the highest-priority index.
  - The grant goes to the first i with `req_valid[i]`, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - `req_ready[i] = grant[i] & s1_free & !rst`.
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
  - On a transfer, the operands and i load into S1, `v1` is set, and `ptr` becomes (i+1) mod NUM_REQ.
  - `ptr` is unchanged when no transfer occurs.
- S1 -> S2:
  - On `s1_adv`, `p2` takes the signed product of `a1` and `b1`, `id2` takes `id1`, and `v2` is set.
  - `v1` is cleared unless a new transfer loads S1 in the same cycle.
- S2 output:
  - `res_valid = v2`; `res_product = p2`; `res_id = id2`.
  - On `res_valid & res_ready` with no `s1_adv`, `v2` clears.
- Simultaneous events:
  - Accept and advance may happen in the same cycle; both stages then update at once, with no bubble.
- Hold rules:
  - While `res_valid & !res_ready`, `res_product` and `res_id` hold stable.
  - Data registers load only on their enable, never on idle cycles.
- Requester contract:
  - Once `req_valid[i]` is raised, the requester holds it and its operands stable until accepted.
  - Deasserting early is tolerated, but then no fairness guarantee holds for that requester.
- Arithmetic:
  - Full 16-bit signed result; no truncation or saturation.
  - Example: -128 * -128 = +16384 (0x4000).
- Reset:
  - `v1`, `v2` clear to 0; `ptr` resets to 0.
  - `res_product` and `res_id` reset to 0, and `res_valid` reads 0.
  - `req_ready` reads 0 during reset.
  - Reset asserted mid-operation discards all in-flight products; nothing is emitted afterward for them.

## Timing
- Latency: a transfer in cycle c gives `res_valid` high in cycle c+2 if `res_ready` was high.
- Throughput: one transfer per cycle while `res_ready` stays high.
- Backpressure:
  - With `res_ready` low, the pipe holds two results.
  - `req_ready` then drops to 0 from the cycle after the second accept.
  - The first cycle with `res_ready` high re-enables acceptance in that same cycle, combinationally.
- `req_ready` depends combinationally on `req_valid`, `ptr`, `v1`, `v2` and `res_ready`. It has no path to `req_a` or `req_b`.
- Starvation bound: a continuously valid requester is granted within NUM_REQ accepted transfers.

## Test plan
- Single request: requester 2 presents a=0x7F, b=0x80 at cycle 0 with `res_ready`=1. Required: `req_ready`=0b0100 in cycle 0, then `res_valid`=1 in cycle 2 with `res_product`=0xC080 and `res_id`=2.
- Contention: all four valid from reset, each with a=i+1, b=0xFF, `res_ready`=1. Required: grants in order 0,1,2,3 on consecutive cycles; results 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC with ids 0..3 in cycles 2..5.
- Round-robin fairness: requesters 0 and 3 both continuously valid, 8 transfers. Required: grants alternate 0,3,0,3,…; neither requester waits more than one transfer.
- Backpressure: `res_ready`=0 while requester 1 streams (0x80,0x80), (0xFF,0xFF), (0x7F,0x7F). Required: only two accepts, then `req_ready`=0 and `res_product`=0x4000 held stable. After raising `res_ready`, results arrive as 0x4000, 0x0001, 0x3F01, with no loss or duplication.
- Reset mid-operation: assert `rst` for one cycle while `v1`=`v2`=1. Required: the next cycle has `res_valid`=0, `res_product`=0, `res_id`=0, `ptr`=0, and no stale result ever appears.
- Random regression: 10k cycles with random valid, operands and `res_ready`. A scoreboard per id checks `res_product` equals a*b signed and that per-requester order is preserved.
